// File: rtl/xgriscv_rf_pkg.sv
// Shared defaults for the xgriscv multi-port register file and its scoreboard.
package xgriscv_rf_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned IDXW_DEF = $clog2(NREG_DEF);
  localparam int unsigned ZERO_IDX = 0;

endpackage

// File: rtl/xgriscv_rf_scoreboard.sv
// Busy-bit scoreboard: issue sets, writeback clears (set wins), and per-read-port hazard flags.
module xgriscv_rf_scoreboard
  import xgriscv_rf_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int IDXW = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*IDXW-1:0] ra,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*IDXW-1:0] wa,
  input  logic                iss_vld,
  input  logic [IDXW-1:0]     iss_idx,
  output logic [NRD-1:0]      rd_busy,
  output logic [NREG-1:0]     busy_vec
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  always_comb begin
    busy_next = busy;
    for (int j = 0; j < NWR; j++) begin
      if (we[j]) busy_next[wa[j*IDXW +: IDXW]] = 1'b0;
    end
    // Applied after the clears so a new producer supersedes the retiring one.
    if (iss_vld) busy_next[iss_idx] = 1'b1;
    busy_next[ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  assign busy_vec = busy;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_busy
      logic [IDXW-1:0] a;
      logic            wr_hit;
      assign a = ra[gi*IDXW +: IDXW];

      always_comb begin
        wr_hit = 1'b0;
        for (int j = 0; j < NWR; j++) begin
          if (we[j] && (wa[j*IDXW +: IDXW] == a)) wr_hit = 1'b1;
        end
      end

      assign rd_busy[gi] = busy[a] && !wr_hit && (a != IDXW'(ZERO_IDX));
    end
  endgenerate

endmodule

// File: rtl/xgriscv_regfile_mp.sv
// Multi-port register file with x0 hardwired, same-cycle write bypass and busy scoreboard.
// Define XGRISCV_REGFILE_TRACE_EN to print "x%d = %h" for each committed write.
module xgriscv_regfile_mp
  import xgriscv_rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int IDXW = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*IDXW-1:0] ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*IDXW-1:0] wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                iss_vld,
  input  logic [IDXW-1:0]     iss_idx,
  output logic [NREG-1:0]     busy_vec
);

  logic [XLEN-1:0] regs      [NREG];
  logic [XLEN-1:0] regs_next [NREG];
  logic [NWR-1:0]  commit;

  // A port commits only if no higher-numbered port targets the same nonzero register.
  always_comb begin
    commit = '0;
    for (int j = 0; j < NWR; j++) begin
      commit[j] = we[j] && (wa[j*IDXW +: IDXW] != IDXW'(ZERO_IDX));
      for (int k = j + 1; k < NWR; k++) begin
        if (we[k] && (wa[k*IDXW +: IDXW] == wa[j*IDXW +: IDXW])) commit[j] = 1'b0;
      end
    end
  end

  always_comb begin
    regs_next = regs;
    for (int j = 0; j < NWR; j++) begin
      if (commit[j]) regs_next[wa[j*IDXW +: IDXW]] = wd[j*XLEN +: XLEN];
    end
    regs_next[ZERO_IDX] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      regs <= regs_next;
    end
  end

`ifdef XGRISCV_REGFILE_TRACE_EN
  always @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < NWR; j++) begin
        if (commit[j]) $display("x%d = %h", wa[j*IDXW +: IDXW], wd[j*XLEN +: XLEN]);
      end
    end
  end
`else
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [IDXW-1:0] a;
      logic [XLEN-1:0] data;
      assign a = ra[gi*IDXW +: IDXW];

      always_comb begin
        data = regs[a];
        for (int j = 0; j < NWR; j++) begin
          if (we[j] && (wa[j*IDXW +: IDXW] == a)) data = wd[j*XLEN +: XLEN];
        end
        // Reset also masks the bypass path so reads are 0 while reset is held.
        if (reset || (a == IDXW'(ZERO_IDX))) data = '0;
      end

      assign rd[gi*XLEN +: XLEN] = data;
    end
  endgenerate

  xgriscv_rf_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .ra       (ra),
    .we       (we),
    .wa       (wa),
    .iss_vld  (iss_vld),
    .iss_idx  (iss_idx),
    .rd_busy  (rd_busy),
    .busy_vec (busy_vec)
  );

endmodule

// File: tb/tb_xgriscv_regfile_mp.sv
// Directed self-checking bench for xgriscv_regfile_mp with 2 read and 2 write ports.
module tb_xgriscv_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rd_busy;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic        iss_vld;
  logic [4:0]  iss_idx;
  logic [31:0] busy_vec;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  xgriscv_regfile_mp dut (
    .clk      (clk),
    .reset    (reset),
    .ra       (ra),
    .rd       (rd),
    .rd_busy  (rd_busy),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .iss_vld  (iss_vld),
    .iss_idx  (iss_idx),
    .busy_vec (busy_vec)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
    we[p] = en;
    wa[p*5 +: 5] = a;
    wd[p*32 +: 32] = d;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    ra[p*5 +: 5] = a;
  endtask

  task automatic idle();
    we = '0;
    wa = '0;
    wd = '0;
    iss_vld = 1'b0;
    iss_idx = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    set_rd(0, 5'd5);
    set_rd(1, 5'd31);
    #2;
    checks++; if (rd[31:0] !== 32'h0) begin errors++; $display("FAIL reset_rd0 got=%h exp=%h", rd[31:0], 32'h0); end
    checks++; if (rd[63:32] !== 32'h0) begin errors++; $display("FAIL reset_rd1 got=%h exp=%h", rd[63:32], 32'h0); end
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL reset_rd_busy got=%b exp=00", rd_busy); end
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy_vec got=%h exp=0", busy_vec); end
    $display("reset: rd0=%h rd1=%h busy_vec=%h", rd[31:0], rd[63:32], busy_vec);
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_bypass();
    set_wr(0, 1'b1, 5'd7, 32'hDEADBEEF);
    set_rd(0, 5'd7);
    set_rd(1, 5'd7);
    #1;
    checks++; if (rd[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rd0 got=%h exp=deadbeef", rd[31:0]); end
    checks++; if (rd[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rd1 got=%h exp=deadbeef", rd[63:32]); end
    tick();
    idle();
    #1;
    checks++; if (rd[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL stored_x7 got=%h exp=deadbeef", rd[31:0]); end
    $display("bypass: x7 bypass/stored = %h", rd[31:0]);
  endtask

  task automatic test_write_conflict();
    set_wr(0, 1'b1, 5'd3, 32'h1111);
    set_wr(1, 1'b1, 5'd3, 32'h2222);
    set_rd(0, 5'd3);
    #1;
    checks++; if (rd[31:0] !== 32'h2222) begin errors++; $display("FAIL conflict_bypass got=%h exp=00002222", rd[31:0]); end
    tick();
    idle();
    #1;
    checks++; if (rd[31:0] !== 32'h2222) begin errors++; $display("FAIL conflict_stored got=%h exp=00002222", rd[31:0]); end
    checks++; if (rd[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL conflict_x7_kept got=%h exp=deadbeef", rd[63:32]); end
    $display("conflict: x3 = %h", rd[31:0]);
  endtask

  task automatic test_x0();
    set_wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
    iss_vld = 1'b1;
    iss_idx = 5'd0;
    set_rd(0, 5'd0);
    #1;
    checks++; if (rd[31:0] !== 32'h0) begin errors++; $display("FAIL x0_bypass got=%h exp=0", rd[31:0]); end
    tick();
    idle();
    #1;
    checks++; if (rd[31:0] !== 32'h0) begin errors++; $display("FAIL x0_stored got=%h exp=0", rd[31:0]); end
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL x0_busy got=%h exp=0", busy_vec); end
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL x0_rd_busy got=%b exp=0", rd_busy[0]); end
    $display("x0: rd0=%h busy_vec=%h", rd[31:0], busy_vec);
  endtask

  task automatic test_scoreboard();
    iss_vld = 1'b1;
    iss_idx = 5'd9;
    set_rd(0, 5'd9);
    #1;
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL sb_not_yet got=%h exp=0", busy_vec); end
    tick();
    idle();
    #1;
    checks++; if (busy_vec !== 32'h0000_0200) begin errors++; $display("FAIL sb_set got=%h exp=00000200", busy_vec); end
    checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_rd_busy_set got=%b exp=1", rd_busy[0]); end
    set_wr(0, 1'b1, 5'd9, 32'h99);
    #1;
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_wb_no_stall got=%b exp=0", rd_busy[0]); end
    checks++; if (rd[31:0] !== 32'h99) begin errors++; $display("FAIL sb_wb_bypass got=%h exp=00000099", rd[31:0]); end
    checks++; if (busy_vec !== 32'h0000_0200) begin errors++; $display("FAIL sb_wb_still_busy got=%h exp=00000200", busy_vec); end
    tick();
    idle();
    #1;
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL sb_cleared got=%h exp=0", busy_vec); end
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_rd_busy_clr got=%b exp=0", rd_busy[0]); end
    iss_vld = 1'b1;
    iss_idx = 5'd9;
    set_wr(1, 1'b1, 5'd9, 32'h55);
    tick();
    idle();
    #1;
    checks++; if (busy_vec !== 32'h0000_0200) begin errors++; $display("FAIL sb_set_wins got=%h exp=00000200", busy_vec); end
    checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_set_wins_rd got=%b exp=1", rd_busy[0]); end
    checks++; if (rd[31:0] !== 32'h55) begin errors++; $display("FAIL sb_set_wins_data got=%h exp=00000055", rd[31:0]); end
    $display("scoreboard: busy_vec=%h rd_busy=%b x9=%h", busy_vec, rd_busy, rd[31:0]);
    set_wr(0, 1'b1, 5'd9, 32'h55);
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    set_wr(0, 1'b1, 5'd1, 32'hA1);
    set_wr(1, 1'b1, 5'd2, 32'hA2);
    tick();
    set_wr(0, 1'b1, 5'd5, 32'hB5);
    set_wr(1, 1'b1, 5'd1, 32'hB1);
    tick();
    idle();
    set_rd(0, 5'd1);
    set_rd(1, 5'd2);
    #1;
    checks++; if (rd[31:0] !== 32'hB1) begin errors++; $display("FAIL b2b_x1 got=%h exp=000000b1", rd[31:0]); end
    checks++; if (rd[63:32] !== 32'hA2) begin errors++; $display("FAIL b2b_x2 got=%h exp=000000a2", rd[63:32]); end
    set_rd(0, 5'd5);
    #1;
    checks++; if (rd[31:0] !== 32'hB5) begin errors++; $display("FAIL b2b_x5 got=%h exp=000000b5", rd[31:0]); end
    $display("back_to_back: x1=%h x2=%h x5=%h", 32'hB1, rd[63:32], rd[31:0]);
  endtask

  task automatic test_async_reset();
    set_wr(0, 1'b1, 5'd4, 32'hAB);
    iss_vld = 1'b1;
    iss_idx = 5'd4;
    tick();
    idle();
    set_rd(0, 5'd4);
    set_rd(1, 5'd7);
    #1;
    checks++; if (rd[31:0] !== 32'hAB) begin errors++; $display("FAIL ar_pre_x4 got=%h exp=000000ab", rd[31:0]); end
    checks++; if (busy_vec !== 32'h0000_0010) begin errors++; $display("FAIL ar_pre_busy got=%h exp=00000010", busy_vec); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (rd[31:0] !== 32'h0) begin errors++; $display("FAIL ar_x4 got=%h exp=0", rd[31:0]); end
    checks++; if (rd[63:32] !== 32'h0) begin errors++; $display("FAIL ar_x7 got=%h exp=0", rd[63:32]); end
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL ar_busy got=%h exp=0", busy_vec); end
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL ar_rd_busy got=%b exp=00", rd_busy); end
    $display("async_reset: x4=%h busy_vec=%h", rd[31:0], busy_vec);
    #1;
    reset = 1'b0;
    tick();
    #1;
    checks++; if (rd[31:0] !== 32'h0) begin errors++; $display("FAIL ar_after_x4 got=%h exp=0", rd[31:0]); end
  endtask

  initial begin
    ra = '0;
    test_reset();
    test_bypass();
    test_write_conflict();
    test_x0();
    test_scoreboard();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xgriscv_regfile_mp.md
Name: xgriscv_regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the next xgriscv core generation.
- Generalises the existing 2-read/1-write file with:
  - configurable width, depth, read-port count and write-port count
  - asynchronous clear of all registers
  - same-cycle write-to-read bypass
  - per-register busy scoreboard for hazard detection
- Sits between the decode stage (reads, issue marking) and the writeback stage (writes, busy clear).

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; must be a power of 2, ≥ 2.
- NRD, 2, number of combinational read ports.
- NWR, 2, number of write ports.
- IDXW, $clog2(NREG), register index width (derived; not overridden).

Ports:
- clk  in  1  core clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all registers and busy bits.
- ra  in  NRD*IDXW  read addresses; port i = ra[i*IDXW +: IDXW].
- rd  out  NRD*XLEN  read data; port i = rd[i*XLEN +: XLEN].
- rd_busy  out  NRD  port i reads a register with an outstanding producer.
- we  in  NWR  write enables.
- wa  in  NWR*IDXW  write addresses.
- wd  in  NWR*XLEN  write data.
- iss_vld  in  1  decode issues an instruction with a destination register.
- iss_idx  in  IDXW  destination register of the issuing instruction.
- busy_vec  out  NREG  current scoreboard state (debug/hazard unit).

Behaviour:
- Storage: NREG x XLEN registers.
  - Async reset sets all registers to 0 and all busy bits to 0.
  - Reset asserted mid-cycle overrides any write or issue in that cycle.
- Register 0:
  - Hardwired to 0; writes to index 0 are discarded.
  - Issue to index 0 never sets busy[0].
  - Reads of index 0 return 0 with rd_busy = 0.
- Write:
  - On posedge clk, for each port j with we[j] = 1 and wa[j] ≠ 0, the register takes wd[j].
  - Two ports writing the same address: the highest-numbered port wins.
- Read (combinational, zero latency): for port i, evaluated in this order:
  1. ra[i] = 0 → rd = 0.
  2. Else if any write port j has we[j] and wa[j] = ra[i] this cycle → rd = wd of the highest such j (bypass).
  3. Else → stored value.
- Scoreboard (busy[NREG-1:0], registered):
  - iss_vld with iss_idx ≠ 0 sets busy[iss_idx] at next posedge.
  - Any we[j] with wa[j] ≠ 0 clears busy[wa[j]] at next posedge.
  - Set and clear of the same index in one cycle: set wins (a new producer supersedes the retiring one).
  - rd_busy[i] = busy[ra[i]] AND NOT (a write to ra[i] this cycle) AND ra[i] ≠ 0. A value being written back this cycle is bypassed and does not stall.
- Reset values: rd = 0 for all ports; rd_busy = 0; busy_vec = 0.
- No internal FSM beyond the busy bits; write latency 1 cycle to storage, 0 cycles to readers via bypass.

Optional Feature:
- Macro: XGRISCV_REGFILE_TRACE_EN.
- Defined:
  - Each committed write (post port-priority, index ≠ 0) prints one line at the posedge it is stored: "x%d = %h" with index and data.
  - Ports are printed in ascending order, skipping losers of a same-address conflict.
  - Trace output is relied on by the grading testbenches and must not change format.
- Undefined: no $display in the module; behaviour otherwise identical.

Decomposition:
- Shared package xgriscv_rf_pkg (or defines header): XLEN, NREG, IDXW defaults, and a zero-register index constant.
- One natural sub-module: xgriscv_rf_scoreboard, which holds busy bits, issue set / writeback clear, set-wins priority and the rd_busy computation.
- Storage, bypass and trace stay in the top.

Test Plan:
- Reset then read all ports at x5, x31 → rd = 0, rd_busy = 0, busy_vec = 0.
- we[0]=1, wa[0]=7, wd[0]=32'hDEADBEEF, same cycle ra[0]=7 → rd[0]=DEADBEEF (bypass); next cycle, no write → still DEADBEEF.
- Same cycle we[0]: x3 ← 32'h1111, we[1]: x3 ← 32'h2222 → x3 = 2222; with trace enabled, a single line "x 3 = 00002222".
- Write x0 ← 32'hFFFFFFFF, plus iss_vld on idx 0 → ra = 0 reads 0, busy_vec[0] = 0.
- Scoreboard sequence:
  - iss_vld idx 9 → next cycle busy_vec[9] = 1 and rd_busy = 1 for ra = 9.
  - Cycle with we to x9 → rd_busy = 0 that cycle; busy[9] clears next cycle.
  - iss idx 9 and we x9 in the same cycle → busy[9] stays 1.
- Assert reset asynchronously mid-cycle while x4 = 32'hAB and busy[4] = 1 → x4 reads 0 and busy[4] = 0 immediately, before the next clk edge.
